// File: rtl/kianv_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package : kianv_bus_pkg
// Purpose : Shared encodings and defaults for the dmem MMIO router.
//           - FSM state encoding (IDLE / REQ / RESP)
//           - target identifiers (RAM / IO / TEST / NONE)
//           - default window bases/sizes and the timeout read-data pattern
// Revision: 1.0 - initial release
// ============================================================================
package kianv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_IO   = 2'd1,
    TGT_TEST = 2'd2,
    TGT_NONE = 2'd3
  } tgt_e;

  localparam logic [31:0] c_ram_base_dflt  = 32'h0000_0000;
  localparam logic [31:0] c_ram_size_dflt  = 32'h0100_0000;
  localparam logic [31:0] c_io_base_dflt   = 32'h1000_0000;
  localparam logic [31:0] c_io_size_dflt   = 32'h0001_0000;
  localparam logic [31:0] c_test_addr_dflt = 32'h2000_0000;
  localparam logic [31:0] c_dead_beef      = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/dmem_router_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : dmem_router_watchdog
// Purpose : 8-bit request-phase watchdog for dmem_mmio_router.
//           Counter clears when a request is accepted and counts every cycle
//           the router spends waiting for a target. expire is high in the
//           last permitted wait cycle (TIMEOUT_CYCLES cycles of waiting).
// Ports   : clk, reset   - clock, synchronous active-high reset
//           clear        - restart the count (request accepted)
//           run          - router is waiting on a target
//           expire       - timeout reached in this cycle
// Revision: 1.0 - initial release
// ============================================================================
module dmem_router_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [7:0] c_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= 8'd0;
    end else if (run && !expire) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Count 0 is the first wait cycle, so c_last marks the TIMEOUT_CYCLES-th.
  assign expire = run && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/dmem_mmio_router.sv
`default_nettype none
// ============================================================================
// Module  : dmem_mmio_router
// Purpose : Routes the CPU data-memory port to main RAM, the IO window or the
//           simulation test port. Request and response are registered; one
//           access is outstanding at a time. Unmapped accesses (and, with the
//           watchdog, hung accesses) complete with a one-cycle bus_err.
// Config  : DMEM_ROUTER_TIMEOUT_EN - enables the request-phase watchdog
//           (dmem_router_watchdog); without it REQ waits indefinitely.
// Ports   : clk, reset                      - clock, sync active-high reset
//           dmem_valid/addr/wmask/wdata     - CPU request (held until ready)
//           dmem_rdata/ready, bus_err       - CPU response (one-cycle pulse)
//           tgt_addr/wmask/wdata            - latched request, all targets
//           ram_valid/ready/rdata           - RAM handshake
//           io_valid/ready/rdata            - IO handshake
//           test_valid/ready                - test port handshake (no rdata)
// Revision: 1.0 - initial release
// ============================================================================
module dmem_mmio_router
  import kianv_bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE       = c_ram_base_dflt,
  parameter logic [31:0] RAM_SIZE       = c_ram_size_dflt,
  parameter logic [31:0] IO_BASE        = c_io_base_dflt,
  parameter logic [31:0] IO_SIZE        = c_io_size_dflt,
  parameter logic [31:0] TEST_ADDR      = c_test_addr_dflt,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        bus_err,
  output logic [31:0] tgt_addr,
  output logic [3:0]  tgt_wmask,
  output logic [31:0] tgt_wdata,
  output logic        ram_valid,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic        io_valid,
  input  logic        io_ready,
  input  logic [31:0] io_rdata,
  output logic        test_valid,
  input  logic        test_ready
);

  // Priority decode: the test word wins over IO, IO over RAM.
  function automatic tgt_e decode(input logic [31:0] addr);
    if (addr[31:2] == TEST_ADDR[31:2]) begin
      return TGT_TEST;
    end else if ((addr & ~(IO_SIZE - 32'd1)) == IO_BASE) begin
      return TGT_IO;
    end else if ((addr & ~(RAM_SIZE - 32'd1)) == RAM_BASE) begin
      return TGT_RAM;
    end
    return TGT_NONE;
  endfunction

  state_e      r_state;
  state_e      w_state_nxt;
  tgt_e        r_tgt;
  tgt_e        w_dec;
  logic [31:0] r_addr;
  logic [3:0]  r_wmask;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_finish;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_err;
  logic        w_tgt_ready;
  logic [31:0] w_tgt_rdata;
  logic        w_expire;

  assign w_dec = decode(dmem_addr);

`ifdef DMEM_ROUTER_TIMEOUT_EN
  dmem_router_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_accept),
    .run    (r_state == ST_REQ),
    .expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_expire         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tgt   <= TGT_NONE;
      r_addr  <= 32'd0;
      r_wmask <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tgt   <= w_dec;
        r_addr  <= dmem_addr;
        r_wmask <= dmem_wmask;
        r_wdata <= dmem_wdata;
      end
      if (w_finish) begin
        r_rdata <= w_rsp_rdata;
        r_err   <= w_rsp_err;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_rsp_rdata = 32'd0;
    w_rsp_err   = 1'b0;
    w_tgt_ready = 1'b0;
    w_tgt_rdata = 32'd0;
    ram_valid   = 1'b0;
    io_valid    = 1'b0;
    test_valid  = 1'b0;
    dmem_ready  = 1'b0;
    bus_err     = 1'b0;

    // Only the latched target's handshake is ever looked at.
    case (r_tgt)
      TGT_RAM: begin
        w_tgt_ready = ram_ready;
        w_tgt_rdata = ram_rdata;
      end
      TGT_IO: begin
        w_tgt_ready = io_ready;
        w_tgt_rdata = io_rdata;
      end
      TGT_TEST: begin
        w_tgt_ready = test_ready;
      end
      default: begin
        w_tgt_ready = 1'b0;
      end
    endcase

    case (r_state)
      ST_IDLE: begin
        if (dmem_valid) begin
          w_accept = 1'b1;
          if (w_dec == TGT_NONE) begin
            // Unmapped: skip REQ entirely and answer with an error.
            w_state_nxt = ST_RESP;
            w_finish    = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        ram_valid  = (r_tgt == TGT_RAM);
        io_valid   = (r_tgt == TGT_IO);
        test_valid = (r_tgt == TGT_TEST);
        if (w_tgt_ready) begin
          w_state_nxt = ST_RESP;
          w_finish    = 1'b1;
          w_rsp_rdata = w_tgt_rdata;
        end else if (w_expire) begin
          w_state_nxt = ST_RESP;
          w_finish    = 1'b1;
          w_rsp_rdata = c_dead_beef;
          w_rsp_err   = 1'b1;
        end
      end
      ST_RESP: begin
        dmem_ready  = 1'b1;
        bus_err     = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign dmem_rdata = r_rdata;
  assign tgt_addr   = r_addr;
  assign tgt_wmask  = r_wmask;
  assign tgt_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_mmio_router
// Purpose : Self-checking bench for dmem_mmio_router: directed vector table,
//           randomized accesses against an address-range reference model,
//           and hand-written reset / back-to-back / timeout sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_router;

  // Bench-local target numbering: 0 RAM, 1 IO, 2 TEST, 3 unmapped.
  localparam int T_RAM  = 0;
  localparam int T_IO   = 1;
  localparam int T_TEST = 2;
  localparam int T_NONE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        bus_err;
  logic [31:0] tgt_addr;
  logic [3:0]  tgt_wmask;
  logic [31:0] tgt_wdata;
  logic        ram_valid, io_valid, test_valid;
  logic        ram_ready, io_ready, test_ready;
  logic [31:0] ram_rdata, io_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_mmio_router dut (
    .clk        (clk),
    .reset      (reset),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .bus_err    (bus_err),
    .tgt_addr   (tgt_addr),
    .tgt_wmask  (tgt_wmask),
    .tgt_wdata  (tgt_wdata),
    .ram_valid  (ram_valid),
    .ram_ready  (ram_ready),
    .ram_rdata  (ram_rdata),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .io_rdata   (io_rdata),
    .test_valid (test_valid),
    .test_ready (test_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    int          dly;     // valid cycles the target waits before ready (0 = same cycle)
    logic [31:0] srd;     // RAM returns srd, IO returns ~srd
    int          tgt;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat; // cycles from accept edge to dmem_ready
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference decode from plain address ranges (priority TEST > IO > RAM).
  function automatic int model_tgt(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    if (x >= 64'h2000_0000 && x < 64'h2000_0004) return T_TEST;
    if (x >= 64'h1000_0000 && x < 64'h1001_0000) return T_IO;
    if (x < 64'h0100_0000) return T_RAM;
    return T_NONE;
  endfunction

  function automatic logic [2:0] onehot(input int t);
    case (t)
      T_RAM:   return 3'b001;
      T_IO:    return 3'b010;
      T_TEST:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic vec_t model_vec(input logic [31:0] a, input logic [3:0] m,
                                     input logic [31:0] d, input int dly,
                                     input logic [31:0] srd);
    vec_t v;
    v.addr = a; v.wmask = m; v.wdata = d; v.dly = dly; v.srd = srd;
    v.tgt = model_tgt(a);
    v.exp_err = (v.tgt == T_NONE);
    v.exp_lat = (v.tgt == T_NONE) ? 1 : dly + 2;
    case (v.tgt)
      T_RAM:   v.exp_rd = srd;
      T_IO:    v.exp_rd = ~srd;
      default: v.exp_rd = 32'd0;
    endcase
    return v;
  endfunction

  // Randomly wiggle the readies of targets that are not selected.
  task automatic noise_readies(input int sel);
    ram_ready  = (sel != T_RAM)  ? 1'($urandom_range(0, 1)) : 1'b0;
    io_ready   = (sel != T_IO)   ? 1'($urandom_range(0, 1)) : 1'b0;
    test_ready = (sel != T_TEST) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Called at a negedge; returns at a negedge with the bus idle.
  task automatic run_access(input vec_t v, input string name);
    int   c, vcount, bad, tbad, lat;
    bit   done;
    logic [2:0] vis;
    dmem_valid = 1'b1; dmem_addr = v.addr; dmem_wmask = v.wmask; dmem_wdata = v.wdata;
    ram_rdata = v.srd; io_rdata = ~v.srd;
    ram_ready = 1'b0; io_ready = 1'b0; test_ready = 1'b0;
    c = 0; vcount = 0; bad = 0; tbad = 0; lat = 0; done = 0;
    while (!done && c < 50) begin
      @(posedge clk); @(negedge clk); c++;
      vis = {test_valid, io_valid, ram_valid};
      if (dmem_ready) begin
        done = 1;
        lat = c;
        check({name, " rdata"}, dmem_rdata, v.exp_rd);
        check({name, " bus_err"}, 32'(bus_err), 32'(v.exp_err));
        dmem_valid = 1'b0;
        noise_readies(T_NONE);
      end else begin
        if (vis != 3'b000) begin
          if (vis != onehot(v.tgt)) bad++;
          else vcount++;
          if (tgt_addr !== v.addr || tgt_wmask !== v.wmask || tgt_wdata !== v.wdata) tbad++;
        end
        noise_readies(v.tgt);
        if (v.tgt != T_NONE && vis == onehot(v.tgt) && vcount == v.dly + 1) begin
          case (v.tgt)
            T_RAM:   ram_ready  = 1'b1;
            T_IO:    io_ready   = 1'b1;
            default: test_ready = 1'b1;
          endcase
        end
      end
    end
    if (!done) begin
      dmem_valid = 1'b0;
      check({name, " completion"}, 32'(done), 32'd1);
    end
    check({name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({name, " valid cycles"}, 32'(vcount), 32'((v.tgt == T_NONE) ? 0 : v.dly + 1));
    check({name, " wrong valids"}, 32'(bad), 32'd0);
    check({name, " tgt fields"}, 32'(tbad), 32'd0);
    @(posedge clk); @(negedge clk);
    check({name, " ready pulse"}, {28'd0, dmem_ready, test_valid, io_valid, ram_valid}, 32'd0);
    ram_ready = 1'b0; io_ready = 1'b0; test_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    int   c, vcount;

    vecs[0] = '{32'h0000_0100, 4'b0000, 32'h0,          1, 32'h1234_5678, T_RAM,  32'h1234_5678, 1'b0, 3};
    vecs[1] = '{32'h2000_0000, 4'b0001, 32'h0000_004F, 1, 32'h5555_5555, T_TEST, 32'h0,         1'b0, 3};
    vecs[2] = '{32'h3000_0000, 4'b0000, 32'h0,          0, 32'h7777_7777, T_NONE, 32'h0,         1'b1, 1};
    vecs[3] = '{32'h1000_0010, 4'b0000, 32'h0,          0, 32'hA5A5_0F0F, T_IO,   32'h5A5A_F0F0, 1'b0, 2};
    vecs[4] = '{32'h00FF_FFFC, 4'b1111, 32'h8765_4321, 2, 32'hCAFE_0001, T_RAM,  32'hCAFE_0001, 1'b0, 4};
    vecs[5] = '{32'h0100_0000, 4'b0000, 32'h0,          0, 32'h1111_1111, T_NONE, 32'h0,         1'b1, 1};
    vecs[6] = '{32'h1000_FFFF, 4'b0000, 32'h0,          0, 32'h1111_2222, T_IO,   32'hEEEE_DDDD, 1'b0, 2};
    vecs[7] = '{32'h1001_0000, 4'b0010, 32'h0000_AB00, 0, 32'h2222_2222, T_NONE, 32'h0,         1'b1, 1};
    vecs[8] = '{32'h2000_0003, 4'b0000, 32'h0,          0, 32'h3333_3333, T_TEST, 32'h0,         1'b0, 2};
    vecs[9] = '{32'h2000_0004, 4'b0000, 32'h0,          3, 32'h4444_4444, T_NONE, 32'h0,         1'b1, 1};

    reset = 1'b1; dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    ram_ready = 1'b0; io_ready = 1'b0; test_ready = 1'b0; ram_rdata = 32'h0; io_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dmem_ready", 32'(dmem_ready), 32'd0);
    check("reset bus_err", 32'(bus_err), 32'd0);
    check("reset dmem_rdata", dmem_rdata, 32'd0);
    check("reset tgt_addr", tgt_addr, 32'd0);
    check("reset tgt_wmask", 32'(tgt_wmask), 32'd0);
    check("reset tgt_wdata", tgt_wdata, 32'd0);
    check("reset valids", {29'd0, test_valid, io_valid, ram_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // Randomized accesses against the range model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0:       a = $urandom & 32'h00FF_FFFF;
        1:       a = 32'h1000_0000 | ($urandom & 32'h0000_FFFF);
        2:       a = 32'h2000_0000 | ($urandom & 32'h3);
        3:       a = 32'h1000_0000 | ($urandom & 32'h3FFF_FFFF);
        default: a = $urandom;
      endcase
      v = model_vec(a, 4'($urandom), $urandom, $urandom_range(0, 4), $urandom);
      run_access(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a RAM request
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0200; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    ram_rdata = 32'h0BAD_0BAD;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("midreq ram_valid", 32'(ram_valid), 32'd1);
    reset = 1'b1; dmem_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midreq reset valids", {29'd0, test_valid, io_valid, ram_valid}, 32'd0);
    check("midreq reset ready", 32'(dmem_ready), 32'd0);
    check("midreq reset tgt_addr", tgt_addr, 32'd0);
    reset = 1'b0; ram_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ram_ready = 1'b0;
    check("late ready ignored", {30'd0, dmem_ready, ram_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("late ready no resp", {30'd0, dmem_ready, bus_err}, 32'd0);
    run_access(model_vec(32'h0000_0204, 4'h0, 32'h0, 0, 32'h600D_600D), "post-reset");

    // Back-to-back RAM read then TEST write
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0040; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
    ram_rdata = 32'hB2B2_0001;
    @(posedge clk); @(negedge clk);
    check("b2b ram_valid", {29'd0, test_valid, io_valid, ram_valid}, 32'd1);
    ram_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ram_ready = 1'b0;
    check("b2b first ready", 32'(dmem_ready), 32'd1);
    check("b2b first rdata", dmem_rdata, 32'hB2B2_0001);
    dmem_addr = 32'h2000_0000; dmem_wmask = 4'b1111; dmem_wdata = 32'hC0DE_0002;
    @(posedge clk); @(negedge clk);
    check("b2b gap", {28'd0, dmem_ready, test_valid, io_valid, ram_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("b2b second accept", {29'd0, test_valid, io_valid, ram_valid}, 32'd4);
    check("b2b second wdata", tgt_wdata, 32'hC0DE_0002);
    check("b2b second wmask", 32'(tgt_wmask), 32'hF);
    test_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    test_ready = 1'b0; dmem_valid = 1'b0;
    check("b2b second ready", {30'd0, dmem_ready, bus_err}, 32'd2);
    check("b2b second rdata", dmem_rdata, 32'd0);
    @(posedge clk); @(negedge clk);
    check("b2b idle", {28'd0, dmem_ready, test_valid, io_valid, ram_valid}, 32'd0);

`ifdef DMEM_ROUTER_TIMEOUT_EN
    // Hung IO write aborts after 255 request cycles
    dmem_valid = 1'b1; dmem_addr = 32'h1000_0020; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_0000;
    c = 0; vcount = 0;
    while (c < 400) begin
      @(posedge clk); @(negedge clk); c++;
      if (dmem_ready) break;
      if (io_valid) vcount++;
    end
    dmem_valid = 1'b0;
    check("timeout valid cycles", 32'(vcount), 32'd255);
    check("timeout latency", 32'(c), 32'd256);
    check("timeout rdata", dmem_rdata, 32'hDEAD_BEEF);
    check("timeout bus_err", 32'(bus_err), 32'd1);
    io_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    io_ready = 1'b0;
    check("timeout late ready", {30'd0, dmem_ready, io_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("timeout late resp", {30'd0, dmem_ready, bus_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
